serial_adder: RTL and testbench

Parametrised bit-serial adder: the sequential successor to the single-bit full adder. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake. It adds them DIGIT bits per clock using a registered carry, then presents the WIDTH-bit sum, carry-out and signed-overflow flag over a second valid/ready handshake. It sits between operand producers and result consumers where area matters more than latency.

---
 rtl/serial_adder_if.sv | 31 +++
 rtl/serial_adder.sv | 87 ++++++++
 tb/tb_serial_adder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand and result valid/ready channels of serial_adder.
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(parameter int WIDTH = 8);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             c_in;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             c_out;
   logic             ovf;
   modport master (
`ifdef SERIAL_ADDER_SUB_EN
      output sub,
`endif
      output in_valid, x, y, c_in, out_ready,
      input  in_ready, out_valid, s, c_out, ovf
   );
   modport slave (
`ifdef SERIAL_ADDER_SUB_EN
      input  sub,
`endif
      input  in_valid, x, y, c_in, out_ready,
      output in_ready, out_valid, s, c_out, ovf
   );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, DIGIT bits per clock over a registered carry.
// Define SERIAL_ADDER_SUB_EN to add subtract mode (x + ~y + 1).
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input logic           clk,
   input logic           rst_n,
   serial_adder_if.slave bus
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   generate
      if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
         $error("serial_adder: illegal WIDTH/DIGIT combination");
      end
   endgenerate
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t             state_q;
   logic [WIDTH-1:0]   x_q, y_q, sum_q;
   logic [CW-1:0]      cnt_q;
   logic               carry_q, ovf_q;
   logic [WIDTH-1:0]   y_in;
   logic               c_in0;
   logic [DIGIT-1:0]   dsum;
   logic               cc, c_top, c_nx;
   logic [WIDTH+DIGIT-1:0] sum_cat;
`ifdef SERIAL_ADDER_SUB_EN
   assign y_in  = bus.sub ? ~bus.y : bus.y;
   assign c_in0 = bus.sub | bus.c_in;
`else
   assign y_in  = bus.y;
   assign c_in0 = bus.c_in;
`endif
   // c_top keeps the carry into the top bit of the digit for the overflow flag
   always_comb begin
      cc    = carry_q;
      c_top = carry_q;
      dsum  = '0;
      for (int i = 0; i < DIGIT; i++) begin
         c_top   = cc;
         dsum[i] = x_q[i] ^ y_q[i] ^ cc;
         cc      = (x_q[i] & y_q[i]) | (cc & (x_q[i] ^ y_q[i]));
      end
      c_nx = cc;
   end
   assign sum_cat = {dsum, sum_q};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (bus.in_valid) begin
               x_q     <= bus.x;
               y_q     <= y_in;
               carry_q <= c_in0;
               cnt_q   <= '0;
               state_q <= RUN;
            end
            RUN: begin
               x_q     <= x_q >> DIGIT;
               y_q     <= y_q >> DIGIT;
               sum_q   <= sum_cat[WIDTH+DIGIT-1:DIGIT];
               carry_q <= c_nx;
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == CW'(N - 1)) begin
                  ovf_q   <= c_top ^ c_nx;
                  state_q <= DONE;
               end
            end
            DONE: if (bus.out_ready) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.s         = sum_q;
   assign bus.c_out     = carry_q;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: two DUTs (DIGIT=1 and DIGIT=4, WIDTH=8) fed the same directed
// vectors; checks results, latency, backpressure and asynchronous reset.
module tb_serial_adder;
   typedef struct {
      logic [7:0] x, y;
      logic       ci, sb;
      logic [7:0] es;
      logic       ec, eo;
   } vec_t;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0, c_in = 1'b0, sub = 1'b0, out_ready = 1'b0;
   logic [7:0] x = '0, y = '0;
   int         errors = 0, checks = 0;
   vec_t       tv[$];
   serial_adder_if #(.WIDTH(8)) if1 ();
   serial_adder_if #(.WIDTH(8)) if4 ();
   assign if1.in_valid = in_valid;
   assign if1.x = x;
   assign if1.y = y;
   assign if1.c_in = c_in;
   assign if1.out_ready = out_ready;
   assign if4.in_valid = in_valid;
   assign if4.x = x;
   assign if4.y = y;
   assign if4.c_in = c_in;
   assign if4.out_ready = out_ready;
`ifdef SERIAL_ADDER_SUB_EN
   assign if1.sub = sub;
   assign if4.sub = sub;
`endif
   serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, got, exp);
      end
   endtask
   task automatic chk_res(input string n, input logic [7:0] es, input logic ec, input logic eo);
      chk({n, " d1 s"}, 32'(if1.s), 32'(es));
      chk({n, " d1 c_out"}, 32'(if1.c_out), 32'(ec));
      chk({n, " d1 ovf"}, 32'(if1.ovf), 32'(eo));
      chk({n, " d4 s"}, 32'(if4.s), 32'(es));
      chk({n, " d4 c_out"}, 32'(if4.c_out), 32'(ec));
      chk({n, " d4 ovf"}, 32'(if4.ovf), 32'(eo));
   endtask
   task automatic accept(input vec_t v);
      @(negedge clk);
      chk("idle in_ready", {if1.in_ready, if4.in_ready}, 2'b11);
      in_valid = 1'b1;
      x = v.x;
      y = v.y;
      c_in = v.ci;
      sub = v.sb;
      @(negedge clk);
      in_valid = 1'b0;
      chk("busy in_ready", {if1.in_ready, if4.in_ready}, 2'b00);
   endtask
   task automatic drain();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("drained out_valid", {if1.out_valid, if4.out_valid}, 2'b00);
      chk("drained in_ready", {if1.in_ready, if4.in_ready}, 2'b11);
   endtask
   task automatic do_op(input vec_t v);
      int l1, l4;
      accept(v);
      l1 = 0;
      l4 = 0;
      for (int n = 1; n <= 20 && l1 == 0; n++) begin
         @(negedge clk);
         if (if4.out_valid && l4 == 0) l4 = n;
         if (if1.out_valid) l1 = n;
      end
      chk("latency d1", 32'(l1), 32'd8);
      chk("latency d4", 32'(l4), 32'd2);
      chk_res("vec", v.es, v.ec, v.eo);
      drain();
   endtask
   task automatic wait_d1();
      int n;
      n = 0;
      while (!if1.out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("d1 done in time", 32'(if1.out_valid), 32'd1);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end
   initial begin
      vec_t v;
      tv.push_back('{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1});
      tv.push_back('{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0});
      tv.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
      tv.push_back('{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1});
      tv.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
      tv.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0});
      tv.push_back('{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
      tv.push_back('{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0});
      tv.push_back('{8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1});
      tv.push_back('{8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0});
`endif
      #3;
      chk("reset in_ready", {if1.in_ready, if4.in_ready}, 2'b11);
      chk("reset out_valid", {if1.out_valid, if4.out_valid}, 2'b00);
      chk_res("reset", 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      foreach (tv[i]) do_op(tv[i]);
      // backpressure: DONE must hold and refuse new operands while out_ready is low
      v = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
      accept(v);
      wait_d1();
      in_valid = 1'b1;
      x = 8'h01;
      y = 8'h01;
      c_in = 1'b0;
      sub = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk_res("hold", 8'h96, 1'b0, 1'b1);
         chk("hold in_ready", {if1.in_ready, if4.in_ready}, 2'b00);
         chk("hold out_valid", {if1.out_valid, if4.out_valid}, 2'b11);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("release not accepted", {if1.in_ready, if1.out_valid}, 2'b10);
      @(negedge clk);
      in_valid = 1'b0;
      chk("accepted after release", 32'(if1.in_ready), 32'd0);
      wait_d1();
      chk_res("after bp", 8'h02, 1'b0, 1'b0);
      drain();
      // asynchronous reset at counter 3 of the DIGIT=1 add
      v = '{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
      accept(v);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst out_valid", {if1.out_valid, if4.out_valid}, 2'b00);
      chk("rst in_ready", {if1.in_ready, if4.in_ready}, 2'b11);
      chk_res("rst", 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op('{8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0});
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
